// File: rtl/sincos_pkg.sv
// Shared types for the sincos request scheduler.
// Angle width, FSM states and the tag carried beside each core op.
package sincos_pkg;

  localparam int SC_W     = 27;
  localparam int TAG_ID_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sc_state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/sincos_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, with wrap.
// Returns a one-hot grant, its index and whether anything was granted.
module sincos_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sincos_scheduler.sv
// Shares one pipelined sincos core among N_REQ requesters; a tag pipe
// matched to the core latency returns each result with its owner's id.
module sincos_scheduler
  import sincos_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT   = 16,
  parameter int W     = SC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0][W-1:0]   req_angle,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      busy,
  output logic                      core_en,
  output logic [W-1:0]              core_angle,
  input  logic [W-1:0]              core_sin,
  input  logic [W-1:0]              core_cos,
  output logic                      rsp_valid,
  output logic [$clog2(N_REQ)-1:0]  rsp_id,
  output logic [W-1:0]              rsp_sin,
  output logic [W-1:0]              rsp_cos
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(LAT + 2);

  sc_state_e      state, next_state;
  logic [IW-1:0]  rr_ptr;
  logic [CW-1:0]  inflight;
  tag_t           tags [LAT];
  tag_t           tag_out;
  logic           grant_en;
  logic [IW-1:0]  gidx;
  logic           issue;
  logic           idle_pipe;
  logic           unused_id;

  assign tag_out   = tags[LAT-1];
  assign idle_pipe = (inflight == '0);

  sincos_rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_valid & {N_REQ{grant_en}}),
    .ptr   (rr_ptr),
    .grant (req_ready),
    .idx   (gidx),
    .any   (issue)
  );

  assign core_angle = issue ? req_angle[gidx] : '0;
  assign core_en    = issue | !idle_pipe;

  if (IW < TAG_ID_W) begin : g_id_hi
    assign unused_id = ^tag_out.id[TAG_ID_W-1:IW];
  end else begin : g_id_full
    assign unused_id = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (flush)           next_state = DRAIN;
        else if (|req_valid) next_state = RUN;
      end
      RUN: begin
        if (flush)                        next_state = DRAIN;
        else if (!(|req_valid) && idle_pipe) next_state = IDLE;
      end
      DRAIN: begin
        if (idle_pipe) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    grant_en   = (state != DRAIN) && !flush;
    flush_done = (state == DRAIN) && idle_pipe;
    busy       = (state != IDLE) || !idle_pipe;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
    end
  end

  // Tag pipe advances in lockstep with the core pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) tags[k] <= '0;
    end else if (core_en) begin
      tags[0] <= '{valid: issue, id: TAG_ID_W'(gidx)};
      for (int k = 1; k < LAT; k++) tags[k] <= tags[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (issue && !tag_out.valid) begin
      inflight <= inflight + CW'(1);
    end else if (!issue && tag_out.valid) begin
      inflight <= inflight - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sin   <= '0;
      rsp_cos   <= '0;
    end else begin
      rsp_valid <= tag_out.valid;
      if (tag_out.valid) begin
        rsp_id  <= tag_out.id[IW-1:0];
        rsp_sin <= core_sin;
        rsp_cos <= core_cos;
      end
    end
  end

endmodule

// File: tb/tb_sincos_scheduler.sv
// Scoreboard bench for sincos_scheduler with a LAT-deep golden core model.
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_sincos_scheduler;
  import sincos_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 16;
  localparam int W   = SC_W;
  localparam int IW  = 2;
  localparam logic [W-1:0] COS0 = 27'h3000000;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0][W-1:0] req_angle;
  logic [N-1:0]        req_ready;
  logic                flush;
  logic                flush_done;
  logic                busy;
  logic                core_en;
  logic [W-1:0]        core_angle;
  logic [W-1:0]        core_sin;
  logic [W-1:0]        core_cos;
  logic                rsp_valid;
  logic [IW-1:0]       rsp_id;
  logic [W-1:0]        rsp_sin;
  logic [W-1:0]        rsp_cos;

  sincos_scheduler #(.N_REQ(N), .LAT(LAT), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_angle  (req_angle),
    .req_ready  (req_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy),
    .core_en    (core_en),
    .core_angle (core_angle),
    .core_sin   (core_sin),
    .core_cos   (core_cos),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sin    (rsp_sin),
    .rsp_cos    (rsp_cos)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] sin_m(input logic [W-1:0] a);
    return a * W'(3) + (a >> 5);
  endfunction

  function automatic logic [W-1:0] cos_m(input logic [W-1:0] a);
    return COS0 - a;
  endfunction

  // Golden core: LAT-stage delay that only advances with en.
  logic [W-1:0] cpipe [LAT];
  always @(posedge clk) begin
    if (core_en) begin
      cpipe[0] <= core_angle;
      for (int k = 1; k < LAT; k++) cpipe[k] <= cpipe[k-1];
    end
  end
  assign core_sin = sin_m(cpipe[LAT-1]);
  assign core_cos = cos_m(cpipe[LAT-1]);

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  s;
    logic [W-1:0]  c;
    int            cyc;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   nrsp = 0;
  int   nfd  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && flush_done) nfd++;
    if (!rst && rsp_valid) begin
      nrsp++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        chk("rsp_sin", 64'(rsp_sin), 64'(mon_e.s));
        chk("rsp_cos", 64'(rsp_cos), 64'(mon_e.c));
        chk("rsp_latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  function automatic int oh2i(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return 0;
  endfunction

  int aseq = 0;

  // One cycle of requests; gnt is the hand-computed expected grant.
  task automatic issue_cycle(input string nm, input logic [N-1:0] v,
                             input logic [N-1:0] gnt,
                             input logic [W-1:0] base);
    logic [W-1:0] a;
    int g;
    @(negedge clk);
    req_valid = v;
    for (int i = 0; i < N; i++) req_angle[i] = base + W'(i * 4099);
    #1;
    chk(nm, 64'(req_ready), 64'(gnt));
    if (gnt != '0) begin
      g = oh2i(gnt);
      a = req_angle[g];
      sb.push_back('{IW'(g), sin_m(a), cos_m(a), cyc + LAT + 1});
    end
  endtask

  task automatic next_base(output logic [W-1:0] b);
    aseq++;
    b = W'(aseq * 123457 + 11);
  endtask

  task automatic drain(input string nm);
    int n;
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk({nm, "_drain_timeout"}, 64'd1, 64'd0);
  endtask

  logic [W-1:0] b;
  logic [N-1:0] g;
  int           n0;
  int           t;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_angle = '0;
    flush     = 1'b0;
    #2;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_core_en", 64'(core_en), 64'd0);
    chk("reset_flush_done", 64'(flush_done), 64'd0);
    chk("reset_rsp_sin", 64'(rsp_sin), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single request on id1 with angle 0.
    issue_cycle("t1_grant", 4'b0010, 4'b0010, W'(-4099));
    @(negedge clk);
    req_valid = '0;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("t1_rsp_seen", 64'(sb.size()), 64'd0);
    @(negedge clk);
    #1;
    chk("t1_busy_low", 64'(busy), 64'd0);
    chk("t1_rsp_pulse_end", 64'(rsp_valid), 64'd0);

    // All four valid: rr_ptr is 2 after granting id1.
    for (int k = 0; k < 12; k++) begin
      next_base(b);
      g = '0;
      g[(2 + k) % N] = 1'b1;
      issue_cycle("t2_grant", 4'b1111, g, b);
    end
    drain("t2");

    // req2 alone, then req0+req2 alternate.
    for (int k = 0; k < 3; k++) begin
      next_base(b);
      issue_cycle("t3_solo", 4'b0100, 4'b0100, b);
    end
    for (int k = 0; k < 4; k++) begin
      next_base(b);
      issue_cycle("t3_alt", 4'b0101, (k % 2 == 0) ? 4'b0001 : 4'b0100, b);
    end
    drain("t3");

    // Five in flight, then flush.
    for (int k = 0; k < 5; k++) begin
      next_base(b);
      issue_cycle("t4_issue", 4'b0001, 4'b0001, b);
    end
    n0 = nrsp;
    nfd = 0;
    @(negedge clk);
    flush = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("t4_ready_blocked", 64'(req_ready), 64'd0);
    t = 0;
    while (!flush_done && t < 60) begin
      @(negedge clk);
      #1;
      chk("t4_no_grant", 64'(req_ready), 64'd0);
      t++;
    end
    chk("t4_flush_done_seen", 64'(flush_done), 64'd1);
    chk("t4_all_rsp", 64'(nrsp - n0), 64'd5);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);
    flush = 1'b0;
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_pulse_once", 64'(nfd), 64'd1);

    // Three in flight, then an asynchronous reset pulse.
    for (int k = 0; k < 3; k++) begin
      next_base(b);
      issue_cycle("t5_issue", 4'b1000, (k == 0) ? 4'b1000 : 4'b1000, b);
    end
    @(negedge clk);
    #2;
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_core_en", 64'(core_en), 64'd0);
    chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_rst_rsp_sin", 64'(rsp_sin), 64'd0);
    chk("t5_rst_rsp_cos", 64'(rsp_cos), 64'd0);
    sb.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    n0 = nrsp;
    repeat (40) @(negedge clk);
    #1;
    chk("t5_no_stale_rsp", 64'(nrsp - n0), 64'd0);

    // Continuous issue, rr_ptr reset to 0.
    for (int k = 0; k < 100; k++) begin
      next_base(b);
      g = '0;
      g[k % N] = 1'b1;
      issue_cycle("t6_grant", 4'b1111, g, b);
      chk("t6_core_en", 64'(core_en), 64'd1);
      if (k > LAT + 1) chk("t6_rsp_stream", 64'(rsp_valid), 64'd1);
    end
    drain("t6");
    chk("t6_final_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
